// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, STATUS bit positions and the FSM state encoding shared by TX and RX.
package uart_pkg;
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam int ST_TX_FULL   = 0;
   localparam int ST_TX_EMPTY  = 1;
   localparam int ST_RX_EMPTY  = 2;
   localparam int ST_RX_FULL   = 3;
   localparam int ST_TX_BUSY   = 4;
   localparam int ST_RX_OVR    = 5;
   localparam int ST_FRAME_ERR = 6;
   localparam int ST_TX_OVF    = 7;
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; a push while full lands only when a pop frees the slot that same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0] wr_q, wr_d, rd_q, rd_d;
   logic do_push, do_pop;
   always_comb begin
      empty = wr_q == rd_q;
      full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      do_pop = pop && !empty;
      do_push = push && (!full || do_pop);
      wr_d = wr_q + {{AW{1'b0}}, do_push};
      rd_d = rd_q + {{AW{1'b0}}, do_pop};
      dout = mem_q[rd_q[AW-1:0]];
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din;
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end
endmodule

// File: rtl/mapped_uart_fifo.sv
// mapped_uart_fifo: memory-mapped full-duplex UART with FIFO-buffered TX/RX, sticky error flags and RX interrupt.
module mapped_uart_fifo #(
   parameter int CLK_FREQ_HZ = 100000000,
   parameter int BAUD_RATE   = 1000000,
   parameter int TX_DEPTH    = 16,
   parameter int RX_DEPTH    = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        sel,
   input  logic [1:0]  addr,
   input  logic        wstrb,
   input  logic        rstrb,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        rxd,
   output logic        txd,
   output logic        irq
);
   import uart_pkg::*;
   localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);
   uart_state_t tx_state_q, tx_state_d, rx_state_q, rx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
   logic [7:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
   logic rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_wait_q, rx_wait_d;
   logic tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d, frame_err_q, frame_err_d;
   logic [31:0] rdata_q, rdata_d, status;
   logic tx_push, tx_pop, tx_full, tx_empty, rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0] tx_dout, rx_dout;
   logic wr, rd, clr, tx_done, rx_done, rx_in, frame_set;
   logic unused_wdata;
   assign unused_wdata = &{1'b0, wdata[31:8]};

   sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk(clk), .resetn(resetn), .push(tx_push), .pop(tx_pop), .din(wdata[7:0]),
      .dout(tx_dout), .full(tx_full), .empty(tx_empty)
   );
   sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk(clk), .resetn(resetn), .push(rx_push), .pop(rx_pop), .din(rx_shift_q),
      .dout(rx_dout), .full(rx_full), .empty(rx_empty)
   );

   always_comb begin
      tx_state_d = tx_state_q;
      tx_bit_d = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_pop = 1'b0;
      tx_done = tx_cnt_q == '0;
      tx_cnt_d = (tx_state_q != S_IDLE && !tx_done) ? tx_cnt_q - 1'b1 : CNT_MAX;
      case (tx_state_q)
         S_IDLE: tx_pop = !tx_empty;
         S_START: if (tx_done) begin
            tx_state_d = S_DATA;
            tx_bit_d = '0;
         end
         S_DATA: if (tx_done) begin
            tx_shift_d = tx_shift_q >> 1;
            tx_bit_d = tx_bit_q + 1'b1;
            if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
         end
         S_STOP: if (tx_done) begin
            tx_pop = !tx_empty;
            tx_state_d = S_IDLE;
         end
      endcase
      // a pop from IDLE or end-of-STOP always starts the next frame with no gap
      if (tx_pop) begin
         tx_shift_d = tx_dout;
         tx_state_d = S_START;
      end
      txd = tx_state_q == S_START ? 1'b0 : tx_state_q == S_DATA ? tx_shift_q[0] : 1'b1;
   end

   always_comb begin
      rx_s1_d = rxd;
      rx_s2_d = rx_s1_q;
      rx_in = rx_s2_q;
      rx_state_d = rx_state_q;
      rx_bit_d = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_wait_d = rx_wait_q;
      rx_push = 1'b0;
      frame_set = 1'b0;
      rx_done = rx_cnt_q == '0;
      rx_cnt_d = rx_done ? CNT_MAX : rx_cnt_q - 1'b1;
      case (rx_state_q)
         S_IDLE: begin
            rx_cnt_d = CNT_HALF;
            if (rx_wait_q) rx_wait_d = !rx_in;
            else if (!rx_in) rx_state_d = S_START;
         end
         S_START: if (rx_done) begin
            rx_state_d = rx_in ? S_IDLE : S_DATA;
            rx_bit_d = '0;
         end
         S_DATA: if (rx_done) begin
            rx_shift_d = {rx_in, rx_shift_q[7:1]};
            rx_bit_d = rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
         end
         S_STOP: if (rx_done) begin
            rx_push = rx_in;
            frame_set = !rx_in;
            rx_wait_d = !rx_in;
            rx_state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      wr = sel && wstrb;
      rd = sel && rstrb;
      tx_push = wr && addr == REG_DATA;
      rx_pop = rd && addr == REG_DATA;
      clr = wr && addr == REG_STATUS;
      tx_ovf_d = (tx_ovf_q && !(clr && wdata[ST_TX_OVF])) || (tx_push && tx_full && !tx_pop);
      rx_ovr_d = (rx_ovr_q && !(clr && wdata[ST_RX_OVR])) || (rx_push && rx_full && !rx_pop);
      frame_err_d = (frame_err_q && !(clr && wdata[ST_FRAME_ERR])) || frame_set;
      status = '0;
      status[ST_TX_FULL] = tx_full;
      status[ST_TX_EMPTY] = tx_empty;
      status[ST_RX_EMPTY] = rx_empty;
      status[ST_RX_FULL] = rx_full;
      status[ST_TX_BUSY] = tx_state_q != S_IDLE || !tx_empty;
      status[ST_RX_OVR] = rx_ovr_q;
      status[ST_FRAME_ERR] = frame_err_q;
      status[ST_TX_OVF] = tx_ovf_q;
      rdata_d = !rd ? rdata_q :
                addr == REG_DATA ? {23'b0, rx_empty, rx_empty ? 8'h00 : rx_dout} :
                addr == REG_STATUS ? status : '0;
      rdata = rdata_q;
      irq = !rx_empty;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         tx_state_q <= S_IDLE;
         rx_state_q <= S_IDLE;
         tx_cnt_q <= CNT_MAX;
         rx_cnt_q <= CNT_HALF;
         tx_bit_q <= '0;
         rx_bit_q <= '0;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
         rx_wait_q <= 1'b0;
         tx_ovf_q <= 1'b0;
         rx_ovr_q <= 1'b0;
         frame_err_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         rx_state_q <= rx_state_d;
         tx_cnt_q <= tx_cnt_d;
         rx_cnt_q <= rx_cnt_d;
         tx_bit_q <= tx_bit_d;
         rx_bit_q <= rx_bit_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         rx_s1_q <= rx_s1_d;
         rx_s2_q <= rx_s2_d;
         rx_wait_q <= rx_wait_d;
         tx_ovf_q <= tx_ovf_d;
         rx_ovr_q <= rx_ovr_d;
         frame_err_q <= frame_err_d;
         rdata_q <= rdata_d;
      end
   end
endmodule

// File: tb/tb_mapped_uart_fifo.sv
// tb_mapped_uart_fifo: directed bench with a TX frame scoreboard (txd monitor) and an RX read scoreboard.
module tb_mapped_uart_fifo;
   logic clk = 1'b0, resetn = 1'b0, sel = 1'b0, wstrb = 1'b0, rstrb = 1'b0;
   logic rxd_drv = 1'b1, loop = 1'b0, mon_en = 1'b1, mon_busy = 1'b0;
   logic [1:0] addr = 2'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic txd, irq, rxd;
   int total = 0, passed = 0, failed = 0, cyc = 0;
   logic [7:0] tx_q[$], rx_q[$];
   int starts[$];

   assign rxd = loop ? txd : rxd_drv;

   mapped_uart_fifo #(.CLK_FREQ_HZ(8000000), .BAUD_RATE(1000000), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
      .clk(clk), .resetn(resetn), .sel(sel), .addr(addr), .wstrb(wstrb), .rstrb(rstrb),
      .wdata(wdata), .rdata(rdata), .rxd(rxd), .txd(txd), .irq(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      sel = 1'b1; wstrb = 1'b1; addr = a; wdata = d;
      tick();
      sel = 1'b0; wstrb = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      sel = 1'b1; rstrb = 1'b1; addr = a;
      tick();
      sel = 1'b0; rstrb = 1'b0;
      d = rdata;
   endtask

   task automatic send_byte(input logic [7:0] b);
      tx_q.push_back(b);
      wr(2'd0, {24'b0, b});
   endtask

   task automatic rx_send(input logic [7:0] b, input logic stop);
      rxd_drv = 1'b0;
      repeat (8) tick();
      for (int i = 0; i < 8; i++) begin
         rxd_drv = b[i];
         repeat (8) tick();
      end
      rxd_drv = stop;
      repeat (8) tick();
      rxd_drv = 1'b1;
      repeat (4) tick();
   endtask

   task automatic tx_drain();
      int n = 0;
      while ((tx_q.size() != 0 || mon_busy) && n < 3000) begin
         tick();
         n++;
      end
      check("tx_drain_bound", 80'(n < 3000), 80'(1));
      repeat (4) tick();
   endtask

   // Captures every frame cycle by cycle and compares it with the ideal 80-cycle waveform
   initial begin
      logic [79:0] w, e;
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (mon_en && resetn && txd === 1'b0) begin
            mon_busy = 1'b1;
            starts.push_back(cyc);
            w[0] = txd;
            for (int k = 1; k < 80; k++) begin
               @(negedge clk);
               w[k] = txd;
            end
            if (tx_q.size() != 0) b = tx_q.pop_front();
            else b = 8'hxx;
            for (int k = 0; k < 80; k++) e[k] = (k < 8) ? 1'b0 : (k >= 72) ? 1'b1 : b[k/8-1];
            check("tx_frame", w, e);
            mon_busy = 1'b0;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: observed no finish, required finish before 1ms");
      $fatal(1);
   end

   initial begin
      logic [31:0] r;
      logic seen;
      int n;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      check("reset_rdata", 80'(rdata), 80'(0));
      check("reset_txd", 80'(txd), 80'(1));
      check("reset_irq", 80'(irq), 80'(0));

      send_byte(8'h55);
      check("tx_idle_before_start", 80'(txd), 80'(1));
      tick();
      check("tx_start_edge", 80'(txd), 80'(0));
      repeat (79) tick();
      rd(2'd1, r);
      check("status_last_stop_cycle", 80'(r), 80'(32'h16));
      rd(2'd1, r);
      check("status_after_frame", 80'(r), 80'(32'h06));
      check("txd_idle_after_frame", 80'(txd), 80'(1));

      starts.delete();
      for (int i = 0; i < 18; i++) begin
         if (i < 17) tx_q.push_back(8'h80 + 8'(i));
         wr(2'd0, 32'h80 + 32'(i));
      end
      rd(2'd1, r);
      check("status_tx_overflow", 80'(r), 80'(32'h95));
      wr(2'd1, 32'h80);
      rd(2'd1, r);
      check("status_ovf_cleared", 80'(r), 80'(32'h15));
      tx_drain();
      n = starts.size();
      check("tx_frame_count", 80'(n), 80'(17));
      check("tx_gapless_span", 80'((n == 17) ? starts[16] - starts[0] : -1), 80'(1280));

      loop = 1'b1;
      rx_q.push_back(8'hA3);
      send_byte(8'hA3);
      n = 0;
      while (!irq && n < 200) begin
         tick();
         n++;
      end
      check("irq_rise", 80'(irq), 80'(1));
      check("irq_after_stop_sample", 80'(n > 76 && n < 90), 80'(1));
      rd(2'd0, r);
      check("rx_loop_data", 80'(r), 80'({24'b0, rx_q.pop_front()}));
      check("irq_cleared", 80'(irq), 80'(0));
      rd(2'd0, r);
      check("rx_empty_read", 80'(r), 80'(32'h100));
      tx_drain();
      loop = 1'b0;

      rxd_drv = 1'b0;
      repeat (3) tick();
      rxd_drv = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         seen = seen | irq;
      end
      check("glitch_irq", 80'(seen), 80'(0));
      rd(2'd1, r);
      check("glitch_status", 80'(r), 80'(32'h06));

      rx_send(8'h3C, 1'b0);
      rd(2'd1, r);
      check("frame_error_set", 80'(r), 80'(32'h46));
      check("frame_error_irq", 80'(irq), 80'(0));
      wr(2'd1, 32'h40);
      rd(2'd1, r);
      check("frame_error_cleared", 80'(r), 80'(32'h06));

      for (int i = 0; i < 17; i++) begin
         if (i < 16) rx_q.push_back(8'(i));
         rx_send(8'(i), 1'b1);
      end
      rd(2'd1, r);
      check("status_rx_overrun", 80'(r), 80'(32'h2A));
      check("irq_rx_full", 80'(irq), 80'(1));
      for (int i = 0; i < 16; i++) begin
         rd(2'd0, r);
         check("rx_fifo_data", 80'(r), 80'({24'b0, rx_q.pop_front()}));
      end
      rd(2'd0, r);
      check("rx_drained", 80'(r), 80'(32'h100));

      mon_en = 1'b0;
      wr(2'd0, 32'h00);
      wr(2'd0, 32'h0F);
      repeat (20) tick();
      check("tx_midframe_low", 80'(txd), 80'(0));
      resetn = 1'b0;
      tick();
      check("reset_midframe_txd", 80'(txd), 80'(1));
      check("reset_midframe_rdata", 80'(rdata), 80'(0));
      resetn = 1'b1;
      rd(2'd1, r);
      check("status_after_reset", 80'(r), 80'(32'h06));
      repeat (20) tick();
      check("txd_quiet_after_reset", 80'(txd), 80'(1));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
